// File: rtl/rv32i_opcodes.sv
// ============================================================================
// rv32i_opcodes : RV32I major-opcode encodings and the canonical NOP word
// Revision      : 1.0
// ============================================================================
`default_nettype none

package rv32i_opcodes;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP        = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } rv32i_opcode_t;

  // addi x0, x0, 0
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : owns PC and IR, issues one valid/ready imem read per fetch
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import rv32i_opcodes::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_start,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_load_value,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             busy,
  output logic             fetch_done,
  output logic             misaligned_fault,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir_pc,
  output logic [31:0]      instr,
  output rv32i_opcode_t    opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             redirect_pending;
  logic [WIDTH-1:0] redirect_value;
  logic             start_misaligned;
  logic             capture;

  // A same-cycle redirect supplies the fetch address, so alignment is judged on it.
  assign start_misaligned = pc_load ? (pc_load_value[1:0] != 2'b00) : (pc[1:0] != 2'b00);
  assign capture          = (state == S_WAIT) && imem_rsp_valid;
  assign imem_addr        = pc;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fetch_start && !start_misaligned) state_next = S_REQ;
      S_REQ:   if (imem_req_ready) state_next = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      imem_req_valid   <= 1'b0;
      busy             <= 1'b0;
      fetch_done       <= 1'b0;
      misaligned_fault <= 1'b0;
      redirect_pending <= 1'b0;
      redirect_value   <= '0;
      pc               <= RESET_PC;
      ir_pc            <= RESET_PC;
      instr            <= RV32I_NOP;
    end else begin
      state          <= state_next;
      imem_req_valid <= (state_next == S_REQ);
      busy           <= (state_next != S_IDLE);
      fetch_done     <= capture;

      if (state == S_IDLE) begin
        if (pc_load) begin
          pc               <= pc_load_value;
          misaligned_fault <= 1'b0;
        end
        if (fetch_start && start_misaligned) misaligned_fault <= 1'b1;
      end else if (pc_load) begin
        redirect_pending <= 1'b1;
        redirect_value   <= pc_load_value;
      end

      if (capture) begin
        instr            <= imem_rsp_data;
        ir_pc            <= pc;
        redirect_pending <= 1'b0;
        if (pc_load)               pc <= pc_load_value;
        else if (redirect_pending) pc <= redirect_value;
        else                       pc <= pc + WIDTH'(4);
      end
    end
  end

  assign opcode = rv32i_opcode_t'(instr[6:0]);
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

endmodule

`default_nettype wire
